// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State encodings are plain constants so legacy netlists keep the same codes.
package fetch_pkg;

    localparam int INSN_BYTES = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fifo_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs between the cache port and decode.
// 2**FIFO_DEPTH entries, no bypass; clear wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic                clear,
    input  fifo_entry_t         wdata,
    output fifo_entry_t         rdata,
    output logic [FIFO_DEPTH:0] count,
    output logic                full,
    output logic                empty
);

    localparam int ENTRIES = 1 << FIFO_DEPTH;
    localparam logic [FIFO_DEPTH:0] ENTRIES_CNT = ENTRIES[FIFO_DEPTH:0];

    fifo_entry_t           mem [ENTRIES];
    logic [FIFO_DEPTH-1:0] wr_ptr;
    logic [FIFO_DEPTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == ENTRIES_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; a clear discards everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + FIFO_DEPTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFO_DEPTH'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_DEPTH+1)'(1);
                2'b01:   count <= count - (FIFO_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, cache request port, prefetch FIFO, redirect
// and FENCE.I handling. Optional FETCH_STATS_EN adds fetch/stall counters.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_RUN   | normal fetch; request whenever the FIFO has room
//   ST_DRAIN | redirect arrived mid-miss; hold address until the word lands,
//            | discard it, then restart at saved_pc
//   ST_FLUSH | one cycle of cache_flush with no request outstanding
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fence_i,
    output logic        cache_valid,
    input  logic        cache_ready,
    output logic [31:0] cache_addr,
    input  logic [31:0] cache_rdata,
    output logic        cache_flush,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_data
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stall
`endif
);

    localparam int ENTRIES = 1 << FIFO_DEPTH;
    localparam logic [FIFO_DEPTH:0] ENTRIES_CNT = ENTRIES[FIFO_DEPTH:0];

    logic [1:0]          state;
    logic [31:0]         fetch_pc;
    logic [31:0]         saved_pc;
    logic                fence_pend;
    logic                active;

    logic [FIFO_DEPTH:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    fifo_entry_t         head;
    fifo_entry_t         push_entry;

    logic                ctrl;
    logic                req_done;
    logic                miss_pend;
    logic                push;
    logic                pop;
    logic [31:0]         target_pc;

    // Request enable per state; nothing is issued until the first edge after reset.
    always_comb begin
        cache_valid = 1'b0;
        case (state)
            ST_RUN:   cache_valid = active && (fifo_count < ENTRIES_CNT);
            ST_DRAIN: cache_valid = 1'b1;
            default:  cache_valid = 1'b0;
        endcase
    end

    assign cache_flush = (state == ST_FLUSH);
    assign cache_addr  = fetch_pc;

    assign ctrl       = redirect_valid || fence_i;
    assign target_pc  = align_pc(redirect_pc);
    assign req_done   = cache_valid && cache_ready;
    assign miss_pend  = cache_valid && !cache_ready;
    assign push       = (state == ST_RUN) && req_done && !ctrl && !fifo_full;
    assign pop        = instr_valid && instr_ready;
    assign push_entry = {fetch_pc, cache_rdata};

    assign instr_valid = !fifo_empty;
    assign instr_pc    = head.pc;
    assign instr_data  = head.data;

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (ctrl),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fetch FSM: PC advance, redirect capture, drain and flush sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            fetch_pc   <= RESET_PC;
            saved_pc   <= RESET_PC;
            fence_pend <= 1'b0;
            active     <= 1'b0;
        end else begin
            active <= 1'b1;
            case (state)
                ST_RUN: begin
                    if (ctrl) begin
                        if (miss_pend) begin
                            // The cache is mid-miss on fetch_pc; keep it stable.
                            state      <= ST_DRAIN;
                            saved_pc   <= target_pc;
                            fence_pend <= fence_i;
                        end else if (fence_i) begin
                            state    <= ST_FLUSH;
                            saved_pc <= target_pc;
                        end else begin
                            fetch_pc <= target_pc;
                        end
                    end else if (req_done) begin
                        fetch_pc <= fetch_pc + 32'(INSN_BYTES);
                    end
                end
                ST_DRAIN: begin
                    if (ctrl) saved_pc <= target_pc;
                    if (fence_i) fence_pend <= 1'b1;
                    if (req_done) begin
                        fetch_pc <= ctrl ? target_pc : saved_pc;
                        saved_pc <= ctrl ? target_pc : saved_pc;
                        state    <= (fence_pend || fence_i) ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // No request is outstanding here, so the invalidate cannot race a fill.
                    fetch_pc   <= ctrl ? target_pc : saved_pc;
                    state      <= ST_RUN;
                    fence_pend <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    // Free-running performance counters; wrap silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
        end else begin
            if (push)      stat_fetched <= stat_fetched + 32'd1;
            if (miss_pend) stat_stall   <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, data}
// words, a monitor pops and compares whenever decode accepts a word.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fence_i = 1'b0;
    logic        cache_valid;
    logic        cache_ready;
    logic [31:0] cache_addr;
    logic [31:0] cache_rdata;
    logic        cache_flush;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_pc;
    logic [31:0] instr_data;
    logic        hit = 1'b1;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_stall;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   hs_cnt = 0;
    int   flush_cnt = 0;
    exp_t exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign cache_ready = hit;
    assign cache_rdata = mem_word(cache_addr);

    fetch_unit #(
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fence_i        (fence_i),
        .cache_valid    (cache_valid),
        .cache_ready    (cache_ready),
        .cache_addr     (cache_addr),
        .cache_rdata    (cache_rdata),
        .cache_flush    (cache_flush),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_pc       (instr_pc),
        .instr_data     (instr_data)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_stall     (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && cache_valid && cache_ready) hs_cnt++;
            if (rst && cache_flush) begin
                flush_cnt++;
                chk("flush_with_valid", 32'(cache_valid), 32'd0);
            end
            if (rst && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got pc %h, expected no word", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_pc", instr_pc, e.pc);
                    chk("word_data", instr_data, e.data);
                end
            end
        end
    endtask

    // Asserts reset, checks reset outputs and drained scoreboard, then
    // releases reset at a negedge (cycle C0); C1 starts at the next posedge.
    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        fence_i        = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        hit            = 1'b1;
        #1;
        chk("rst_cache_valid", 32'(cache_valid), 32'd0);
        chk("rst_cache_flush", 32'(cache_flush), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_cache_addr", cache_addr, 32'h100);
`ifdef FETCH_STATS_EN
        chk("rst_stat_fetched", stat_fetched, 32'd0);
        chk("rst_stat_stall", stat_stall, 32'd0);
`endif
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        hs_cnt    = 0;
        flush_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        #2;

        // 1: streaming after reset, one word per cycle
        do_reset();
        hit = 1'b1;
        instr_ready = 1'b1;
        expect_word(32'h100);
        expect_word(32'h104);
        expect_word(32'h108);
        next_cycle();
        at_neg();
        chk("t1_first_valid", 32'(cache_valid), 32'd1);
        chk("t1_first_addr", cache_addr, 32'h100);
        chk("t1_no_bypass", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            at_neg();
            chk("t1_stream_pc", instr_pc, 32'h100 + 32'(4 * i));
        end
        next_cycle();
        instr_ready = 1'b0;

        // 2: fill with decode stalled, then one pop
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
        end
        at_neg();
        chk("t2_full_no_req", 32'(cache_valid), 32'd0);
        chk("t2_push_count", 32'(hs_cnt), 32'd4);
        chk("t2_head_pc", instr_pc, 32'h100);
        expect_word(32'h100);
        next_cycle();
        instr_ready = 1'b1;
        at_neg();
        chk("t2_pop_no_issue", 32'(cache_valid), 32'd0);
        next_cycle();
        instr_ready = 1'b0;
        at_neg();
        chk("t2_reissue_valid", 32'(cache_valid), 32'd1);
        chk("t2_reissue_addr", cache_addr, 32'h110);
        chk("t2_head_after_pop", instr_pc, 32'h104);
        next_cycle();
        at_neg();
        chk("t2_full_again", 32'(cache_valid), 32'd0);
        chk("t2_push_total", 32'(hs_cnt), 32'd5);
`ifdef FETCH_STATS_EN
        chk("t2_stat_fetched", stat_fetched, 32'd5);
`endif

        // 3: five-cycle miss at 0x200
        do_reset();
        instr_ready = 1'b1;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        next_cycle();
        redirect_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("t3_miss_addr", cache_addr, 32'h200);
            chk("t3_miss_valid", 32'(cache_valid), 32'd1);
            chk("t3_miss_no_word", 32'(instr_valid), 32'd0);
            if (i < 4) next_cycle();
        end
        next_cycle();
        hit = 1'b1;
        expect_word(32'h200);
        at_neg();
        chk("t3_hit_addr", cache_addr, 32'h200);
`ifdef FETCH_STATS_EN
        chk("t3_stat_stall", stat_stall, 32'd5);
`endif
        next_cycle();
        hit = 1'b0;
        at_neg();
        chk("t3_word_pc", instr_pc, 32'h200);
`ifdef FETCH_STATS_EN
        chk("t3_stat_fetched", stat_fetched, 32'd1);
`endif
        next_cycle();

        // 4: redirect to 0x403 while missing at 0x200
        do_reset();
        instr_ready = 1'b1;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        next_cycle();
        redirect_valid = 1'b0;
        hit = 1'b0;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h403;
        at_neg();
        chk("t4_redirect_cycle_addr", cache_addr, 32'h200);
        next_cycle();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("t4_drain_addr", cache_addr, 32'h200);
            chk("t4_drain_valid", 32'(cache_valid), 32'd1);
            chk("t4_drain_no_word", 32'(instr_valid), 32'd0);
            next_cycle();
        end
        hit = 1'b1;
        at_neg();
        chk("t4_drain_done_addr", cache_addr, 32'h200);
        next_cycle();
        expect_word(32'h400);
        at_neg();
        chk("t4_resume_addr", cache_addr, 32'h400);
        chk("t4_discarded", 32'(instr_valid), 32'd0);
        next_cycle();
        hit = 1'b0;
        at_neg();
        chk("t4_word_valid", 32'(instr_valid), 32'd1);
        next_cycle();

        // 5: fence_i on a hit cycle
        do_reset();
        instr_ready = 1'b1;
        expect_word(32'h100);
        next_cycle();
        next_cycle();
        next_cycle();
        instr_ready = 1'b0;
        fence_i     = 1'b1;
        redirect_pc = 32'h80;
        next_cycle();
        fence_i     = 1'b0;
        redirect_pc = 32'h0;
        at_neg();
        chk("t5_fifo_cleared", 32'(instr_valid), 32'd0);
        chk("t5_flush", 32'(cache_flush), 32'd1);
        chk("t5_flush_no_valid", 32'(cache_valid), 32'd0);
        next_cycle();
        instr_ready = 1'b1;
        expect_word(32'h80);
        at_neg();
        chk("t5_resume_addr", cache_addr, 32'h80);
        chk("t5_resume_valid", 32'(cache_valid), 32'd1);
        chk("t5_flush_done", 32'(cache_flush), 32'd0);
        next_cycle();
        hit = 1'b0;
        at_neg();
        chk("t5_word_pc", instr_pc, 32'h80);
        next_cycle();

        // 6: simultaneous fence_i/redirect, then reset mid-miss
        do_reset();
        next_cycle();
        next_cycle();
        fence_i        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        next_cycle();
        fence_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h90;
        at_neg();
        chk("t6_flush", 32'(cache_flush), 32'd1);
        chk("t6_cleared", 32'(instr_valid), 32'd0);
        next_cycle();
        at_neg();
        chk("t6_resume_addr", cache_addr, 32'h80);
        chk("t6_flush_pulses", 32'(flush_cnt), 32'd1);
        next_cycle();
        hit = 1'b0;
        #2;
        chk("t6_miss_addr", cache_addr, 32'h84);
        rst = 1'b0;
        #1;
        chk("t6_async_valid", 32'(cache_valid), 32'd0);
        chk("t6_async_addr", cache_addr, 32'h100);
        chk("t6_async_instr_valid", 32'(instr_valid), 32'd0);
        do_reset();
        instr_ready = 1'b1;
        expect_word(32'h100);
        next_cycle();
        at_neg();
        chk("t6_restart_addr", cache_addr, 32'h100);
        next_cycle();
        hit = 1'b0;
        at_neg();
        chk("t6_restart_word", instr_pc, 32'h100);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("final_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
